// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit teaching CPU.
// Drives the register file's state, indices and write-back data, and the instruction ROM address.
module exec_sequencer #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [31:0]     instr,
  input  logic [7:0]      rsv,
  input  logic [7:0]      rtv,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [7:0]      result,
  output logic            instruction_invalid,
  output logic            halted,
  output logic [15:0]     retired
);

  // Encodings shared with the register file; StHalt is deliberately distinct from StOutput.
  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StRf     = 3'd2,
    StEx     = 3'd3,
    StWb     = 3'd4,
    StOutput = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpHalt  = 6'h3F;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [4:0]      rs_q, rs_d;
  logic [4:0]      rt_q, rt_d;
  logic [4:0]      rd_q, rd_d;
  logic [7:0]      result_q, result_d;
  logic            invalid_q, invalid_d;
  logic            halted_q, halted_d;
  logic [15:0]     retired_q, retired_d;
  logic [5:0]      opcode_q, opcode_d;
  logic [5:0]      funct_q, funct_d;
  logic [7:0]      imm_q, imm_d;

  logic [5:0] instr_op;
  logic [5:0] instr_fn;
  logic       instr_valid;
  logic [7:0] alu_res;
  logic       beq_taken;
  logic       unused_instr;

  assign instr_op     = instr[31:26];
  assign instr_fn     = instr[5:0];
  assign unused_instr = ^instr[10:8];

  always_comb begin
    instr_valid = 1'b0;
    case (instr_op)
      OpRType: begin
        case (instr_fn)
          FnAdd, FnSub, FnAnd, FnOr, FnSlt: instr_valid = 1'b1;
          default:                          instr_valid = 1'b0;
        endcase
      end
      OpBeq, OpAddi, OpHalt: instr_valid = 1'b1;
      default:               instr_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = 8'h00;
    case (opcode_q)
      OpRType: begin
        case (funct_q)
          FnAdd:   alu_res = rsv + rtv;
          FnSub:   alu_res = rsv - rtv;
          FnAnd:   alu_res = rsv & rtv;
          FnOr:    alu_res = rsv | rtv;
          FnSlt:   alu_res = {7'd0, $signed(rsv) < $signed(rtv)};
          default: alu_res = 8'h00;
        endcase
      end
      OpAddi:  alu_res = rsv + imm_q;
      default: alu_res = 8'h00;
    endcase
  end

  assign beq_taken = (opcode_q == OpBeq) && (rsv == rtv);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    result_d  = result_q;
    invalid_d = invalid_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    imm_d     = imm_q;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        opcode_d  = instr_op;
        funct_d   = instr_fn;
        imm_d     = instr[7:0];
        rs_d      = instr[25:21];
        rt_d      = instr[20:16];
        rd_d      = (instr_op == OpAddi) ? instr[20:16] : instr[15:11];
        invalid_d = ~instr_valid;
        state_d   = (instr_op == OpHalt) ? StOutput : StRf;
      end
      StRf: state_d = StEx;
      StEx: begin
        state_d  = StWb;
        result_d = invalid_q ? 8'h00 : alu_res;
        // beq must never write the register file.
        if (opcode_q == OpBeq) begin
          rd_d = 5'd0;
        end
        if (beq_taken) begin
          pc_d = pc_q + PC_W'(1) + PC_W'(imm_q);
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      StWb: begin
        state_d = StFetch;
        if (retired_q != 16'hFFFF) begin
          retired_d = retired_q + 16'd1;
        end
      end
      StOutput: begin
        state_d  = StHalt;
        halted_d = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StFetch;
      pc_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      invalid_q <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
      opcode_q  <= '0;
      funct_q   <= '0;
      imm_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      invalid_q <= invalid_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      imm_q     <= imm_d;
    end
  end

  assign pc                  = pc_q;
  assign state               = state_q;
  assign rs                  = rs_q;
  assign rt                  = rt_q;
  assign rd                  = rd_q;
  assign result              = result_q;
  assign instruction_invalid = invalid_q;
  assign halted              = halted_q;
  assign retired             = retired_q;

endmodule
